// File: rtl/vpi_pub_array_scan.sv
// Register-array access target: a 2-D mem with a non-zero base index, a registered read port,
// a changed-write counter, a summing scan FSM and a registered packed-lane incrementer.
module vpi_pub_array_scan #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4,
    parameter int BASE  = 3,
    parameter int LANES = 62,
    parameter int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int SUM_W = WIDTH + IDX_W + 1,
    parameter int CNT_W = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_en,
    input  logic [IDX_W-1:0]             wr_idx,
    input  logic [WIDTH-1:0]             wr_data,
    input  logic [IDX_W-1:0]             rd_idx,
    output logic [WIDTH-1:0]             rd_data,
    input  logic                         scan_start,
    output logic                         scan_busy,
    output logic                         scan_done,
    output logic [SUM_W-1:0]             scan_sum,
    output logic [CNT_W-1:0]             chg_cnt,
    input  logic [LANES-1:0][WIDTH-1:0]  lanes_in,
    output logic [LANES-1:0][WIDTH-1:0]  lanes_out
);

    localparam int AW = $clog2(BASE + DEPTH);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    logic [WIDTH-1:0] mem [BASE+DEPTH-1:BASE];
    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [SUM_W-1:0] acc;
    logic             wr_ok;
    logic             rd_ok;

    // Offsets are 0-based; the array itself is addressed from BASE upwards.
    function automatic logic [AW-1:0] ent(input logic [IDX_W-1:0] idx);
        return AW'(BASE + int'(idx));
    endfunction

    assign wr_ok = wr_en && (int'(wr_idx) < DEPTH);
    assign rd_ok = int'(rd_idx) < DEPTH;

    // NOTE: mem is cleared by reset because the scan and read port must observe zeros right
    // after reset; this forces a flop array rather than a RAM macro, which is fine at this size.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = BASE; i < BASE + DEPTH; i++) mem[AW'(i)] <= '0;
            chg_cnt <= '0;
        end else if (wr_ok) begin
            mem[ent(wr_idx)] <= wr_data;
            if (mem[ent(wr_idx)] != wr_data && chg_cnt != '1)
                chg_cnt <= chg_cnt + CNT_W'(1);
        end
    end

    // NOTE: non-blocking assignments make rd_data sample mem before a same-edge write lands,
    // so a colliding read returns the old entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rd_data <= '0;
        else
            rd_data <= rd_ok ? mem[ent(rd_idx)] : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lanes_out <= '0;
        end else begin
            for (int i = 0; i < LANES; i++) lanes_out[i] <= lanes_in[i] + WIDTH'(1);
        end
    end

    // Done pulse and the sum update leave DONE together, so scan_sum is valid with scan_done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            acc       <= '0;
            scan_busy <= 1'b0;
            scan_done <= 1'b0;
            scan_sum  <= '0;
        end else begin
            scan_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (scan_start) begin
                        state     <= SCAN;
                        ptr       <= '0;
                        acc       <= '0;
                        scan_busy <= 1'b1;
                    end
                end
                SCAN: begin
                    acc <= acc + SUM_W'(mem[ent(ptr)]);
                    ptr <= ptr + IDX_W'(1);
                    if (int'(ptr) == DEPTH - 1)
                        state <= DONE;
                end
                DONE: begin
                    scan_sum  <= acc;
                    scan_done <= 1'b1;
                    scan_busy <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    scan_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vpi_pub_array_scan.sv
// Scoreboard bench for vpi_pub_array_scan: a cycle-level reference model queues expected
// outputs per clock edge, a monitor pops and compares them, plus directed boundary checks.
module tb_vpi_pub_array_scan;

    localparam int WIDTH = 2;
    localparam int DEPTH = 4;
    localparam int BASE  = 3;
    localparam int LANES = 62;
    localparam int IDX_W = 2;
    localparam int SUM_W = WIDTH + IDX_W + 1;
    localparam int CNT_W = 16;

    typedef logic [LANES-1:0][WIDTH-1:0] lanes_t;

    typedef struct {
        int     rd;
        int     cnt;
        bit     busy;
        bit     done;
        int     sum;
        lanes_t lanes;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic [WIDTH-1:0] wr_data;
    logic [IDX_W-1:0] rd_idx;
    logic [WIDTH-1:0] rd_data;
    logic             scan_start;
    logic             scan_busy;
    logic             scan_done;
    logic [SUM_W-1:0] scan_sum;
    logic [CNT_W-1:0] chg_cnt;
    lanes_t           lanes_in;
    lanes_t           lanes_out;

    int n_vec = 0;
    int n_bad = 0;
    exp_t sb[$];

    vpi_pub_array_scan #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .BASE(BASE), .LANES(LANES)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
        .rd_idx(rd_idx), .rd_data(rd_data),
        .scan_start(scan_start), .scan_busy(scan_busy), .scan_done(scan_done),
        .scan_sum(scan_sum), .chg_cnt(chg_cnt),
        .lanes_in(lanes_in), .lanes_out(lanes_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: entries as plain ints, the scan as "cycles since start".
    int     m_mem[DEPTH];
    int     m_cnt, m_rd, m_sum, m_acc, m_el;
    bit     m_busy, m_done;
    lanes_t m_lanes;

    task automatic model_step();
        exp_t e;
        int   old_mem[DEPTH];
        if (!rst_n) begin
            foreach (m_mem[i]) m_mem[i] = 0;
            m_cnt = 0; m_rd = 0; m_sum = 0; m_acc = 0; m_el = 0;
            m_busy = 0; m_done = 0; m_lanes = '0;
        end else begin
            old_mem = m_mem;
            m_rd = (int'(rd_idx) < DEPTH) ? old_mem[rd_idx] : 0;
            if (wr_en && int'(wr_idx) < DEPTH) begin
                if (old_mem[wr_idx] != int'(wr_data) && m_cnt < (1 << CNT_W) - 1) m_cnt++;
                m_mem[wr_idx] = int'(wr_data);
            end
            m_done = 0;
            if (m_busy) begin
                m_el++;
                if (m_el <= DEPTH) begin
                    m_acc += old_mem[m_el-1];
                end else begin
                    m_sum  = m_acc;
                    m_done = 1;
                    m_busy = 0;
                end
            end else if (scan_start) begin
                m_busy = 1; m_el = 0; m_acc = 0;
            end
            for (int i = 0; i < LANES; i++)
                m_lanes[i] = WIDTH'((int'(lanes_in[i]) + 1) % (1 << WIDTH));
        end
        e.rd = m_rd; e.cnt = m_cnt; e.busy = m_busy; e.done = m_done;
        e.sum = m_sum; e.lanes = m_lanes;
        sb.push_back(e);
    endtask

    always @(posedge clk) model_step();

    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("rd_data",   128'(rd_data),   128'(e.rd));
            check("chg_cnt",   128'(chg_cnt),   128'(e.cnt));
            check("scan_busy", 128'(scan_busy), 128'(e.busy));
            check("scan_done", 128'(scan_done), 128'(e.done));
            check("scan_sum",  128'(scan_sum),  128'(e.sum));
            check("lanes_out", 128'(lanes_out), 128'(e.lanes));
        end
    end

    task automatic reset_mid(input string tag);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check({tag, "_rd_data"},   128'(rd_data),   128'(0));
        check({tag, "_chg_cnt"},   128'(chg_cnt),   128'(0));
        check({tag, "_scan_busy"}, 128'(scan_busy), 128'(0));
        check({tag, "_scan_done"}, 128'(scan_done), 128'(0));
        check({tag, "_scan_sum"},  128'(scan_sum),  128'(0));
        check({tag, "_lanes_out"}, 128'(lanes_out), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Waits for scan_done after a start sampled on the edge just passed; returns edge count.
    task automatic wait_done(output int lat, input bit poke_busy);
        lat = 0;
        while (scan_done !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (poke_busy && lat == 2) scan_start = 1'b1;
            if (lat == 3) scan_start = 1'b0;
        end
    endtask

    initial begin
        logic [WIDTH-1:0] vals [DEPTH];
        int lat;
        vals = '{2'd3, 2'd1, 2'd2, 2'd3};
        rst_n = 1'b0; wr_en = 1'b0; wr_idx = '0; wr_data = '0; rd_idx = '0;
        scan_start = 1'b0; lanes_in = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            wr_en = 1'b1; wr_idx = IDX_W'(i); wr_data = vals[i]; rd_idx = IDX_W'(i);
        end
        @(negedge clk);
        wr_en = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            rd_idx = IDX_W'(i);
            @(negedge clk);
            check("rd_after_write", 128'(rd_data), 128'(vals[i]));
        end
        check("chg_cnt_four", 128'(chg_cnt), 128'(4));
        wr_en = 1'b1; wr_idx = '0; wr_data = 2'd3;
        @(negedge clk);
        wr_en = 1'b0;
        @(negedge clk);
        check("chg_cnt_same_write", 128'(chg_cnt), 128'(4));

        scan_start = 1'b1;
        @(posedge clk);
        #1 scan_start = 1'b0;
        wait_done(lat, 1'b1);
        check("scan_latency", 128'(lat), 128'(DEPTH + 1));
        check("scan_sum_9", 128'(scan_sum), 128'(9));

        @(negedge clk);
        scan_start = 1'b1;
        @(posedge clk);
        #1 scan_start = 1'b0;
        wr_en = 1'b1; wr_idx = 2'd3; wr_data = 2'd0;
        @(posedge clk);
        #1 wr_en = 1'b0;
        wait_done(lat, 1'b0);
        check("midscan_write_sum", 128'(scan_sum), 128'(6));
        check("chg_cnt_five", 128'(chg_cnt), 128'(5));

        @(negedge clk);
        for (int i = 0; i < LANES; i++) lanes_in[i] = 2'b11;
        @(posedge clk);
        #1 check("lanes_wrap", 128'(lanes_out), 128'(0));

        @(negedge clk);
        scan_start = 1'b1;
        @(posedge clk);
        #1 scan_start = 1'b0;
        @(posedge clk);
        reset_mid("midscan_reset");
        repeat (8) @(negedge clk);

        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 149) == 0) begin
                reset_mid("rand_reset");
            end else begin
                @(negedge clk);
                wr_en      = ($urandom_range(0, 2) == 0);
                wr_idx     = IDX_W'($urandom_range(0, DEPTH - 1));
                wr_data    = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
                rd_idx     = IDX_W'($urandom_range(0, DEPTH - 1));
                scan_start = ($urandom_range(0, 7) == 0);
                for (int i = 0; i < LANES; i++)
                    lanes_in[i] = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
            end
        end

        reset_mid("final_reset");
        repeat (3) @(negedge clk);
        check("scoreboard_drained", 128'(sb.size()), 128'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
